// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with base RV integer ops plus the M extension.
// Base ops finish one cycle after acceptance. M ops run on one shared
// iterative datapath: shift-add for multiply and restoring divide, one bit
// per cycle. The latency is fixed at N+2 cycles.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   X, Y                operands (rs1, rs2/imm)
//   m_en, select        op select: m_en=1 -> select[2:0] is funct3, else select[3:0]
//   out_valid/out_ready result handshake; result is held while out_valid
//   result              registered result
module alu_md #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         m_en,
  input  logic [3:0]   select,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result
);
  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  ZERO     = {N{1'b0}};
  localparam logic [N-1:0]  ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0]  MIN_NEG  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  result_q, result_d;
  logic          out_valid_q, out_valid_d;
  // hi/lo form the 2N-bit product, or {remainder, quotient} when dividing
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  b_q, b_d;     // multiplicand or divisor magnitude
  logic [N-1:0]  x_q, x_d;     // original dividend for the divide-by-zero remainder
  logic [2:0]    op_q, op_d;
  logic          sx_q, sx_d, sy_q, sy_d;
  logic          div0_q, div0_d, ovf_q, ovf_d;

  logic [N:0]    sum_s;
  logic [N:0]    shl_s;
  logic [2*N-1:0] prod_s;
  logic [N-1:0]  quo_s, rem_s;
  logic          signed_x_s, signed_y_s;

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
    return ~v + {{(N-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic s);
    return s ? neg_n(v) : v;
  endfunction

  function automatic logic [N-1:0] base_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic [3:0] sel);
    logic [CW-1:0] sh;
    logic [N-1:0]  r;
    sh = y[CW-1:0];
    case (sel)
      4'b0000: r = x + y;
      4'b1000: r = x - y;
      4'b0001: r = x << sh;
      4'b0101: r = x >> sh;
      4'b1101: r = $unsigned($signed(x) >>> sh);
      4'b0010: r = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
      4'b0011: r = {{(N-1){1'b0}}, (x < y)};
      4'b0100: r = x ^ y;
      4'b0110: r = x | y;
      4'b0111: r = x & y;
      4'b1111: r = y;
      default: r = ZERO;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Next-state, datapath step and result selection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    x_d         = x_q;
    op_d        = op_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
    sum_s       = {(N+1){1'b0}};
    shl_s       = {(N+1){1'b0}};
    prod_s      = {(2*N){1'b0}};
    quo_s       = ZERO;
    rem_s       = ZERO;
    signed_x_s  = 1'b0;
    signed_y_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (m_en) begin
            // MUL (000) takes only the low half, so it is treated as unsigned
            signed_x_s = (select[2:0] == 3'b001) || (select[2:0] == 3'b010) ||
                         (select[2:0] == 3'b100) || (select[2:0] == 3'b110);
            signed_y_s = (select[2:0] == 3'b001) || (select[2:0] == 3'b100) ||
                         (select[2:0] == 3'b110);
            sx_d   = signed_x_s & X[N-1];
            sy_d   = signed_y_s & Y[N-1];
            op_d   = select[2:0];
            x_d    = X;
            hi_d   = ZERO;
            div0_d = (Y == ZERO);
            ovf_d  = signed_y_s & select[2] & (X == MIN_NEG) & (Y == ALL_ONES);
            if (select[2]) begin
              lo_d = mag(X, signed_x_s & X[N-1]);
              b_d  = mag(Y, signed_y_s & Y[N-1]);
            end else begin
              b_d  = mag(X, signed_x_s & X[N-1]);
              lo_d = mag(Y, signed_y_s & Y[N-1]);
            end
            cnt_d   = CNT_LAST;
            state_d = S_CALC;
          end else begin
            result_d    = base_op(X, Y, select);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          // Restoring division: shift the next dividend bit into the remainder.
          // The remainder stays below the divisor, so it always fits in N bits.
          shl_s = {hi_q, lo_q[N-1]};
          if (shl_s >= {1'b0, b_q}) begin
            hi_d = shl_s[N-1:0] - b_q;
            lo_d = {lo_q[N-2:0], 1'b1};
          end else begin
            hi_d = shl_s[N-1:0];
            lo_d = {lo_q[N-2:0], 1'b0};
          end
        end else begin
          // Shift-add: the multiplier is consumed from lo as the product fills in
          if (lo_q[0]) begin
            sum_s = {1'b0, hi_q} + {1'b0, b_q};
          end else begin
            sum_s = {1'b0, hi_q};
          end
          hi_d = sum_s[N:1];
          lo_d = {sum_s[0], lo_q[N-1:1]};
        end
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FIX: begin
        if (op_q[2]) begin
          if (div0_q) begin
            quo_s = ALL_ONES;
            rem_s = x_q;
          end else if (ovf_q) begin
            quo_s = x_q;
            rem_s = ZERO;
          end else begin
            quo_s = (sx_q ^ sy_q) ? neg_n(lo_q) : lo_q;
            rem_s = sx_q ? neg_n(hi_q) : hi_q;
          end
          result_d = op_q[1] ? rem_s : quo_s;
        end else begin
          if (sx_q ^ sy_q) begin
            prod_s = ~{hi_q, lo_q} + {{(2*N-1){1'b0}}, 1'b1};
          end else begin
            prod_s = {hi_q, lo_q};
          end
          result_d = (op_q[1:0] == 2'b00) ? prod_s[N-1:0] : prod_s[2*N-1:N];
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      result_q    <= ZERO;
      out_valid_q <= 1'b0;
      hi_q        <= ZERO;
      lo_q        <= ZERO;
      b_q         <= ZERO;
      x_q         <= ZERO;
      op_q        <= 3'b000;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
      x_q         <= x_d;
      op_q        <= op_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv32, ir32, m32, ov32, or32;
  logic [3:0]  s32;
  logic [31:0] x32, y32, r32;
  logic        iv8, ir8, m8, ov8, or8;
  logic [3:0]  s8;
  logic [7:0]  x8, y8, r8;

  alu_md #(.N(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .X(x32), .Y(y32),
    .m_en(m32), .select(s32), .out_valid(ov32), .out_ready(or32), .result(r32)
  );

  alu_md #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .X(x8), .Y(y8),
    .m_en(m8), .select(s8), .out_valid(ov8), .out_ready(or8), .result(r8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values for width n
  function automatic logic [63:0] model(input int n, input bit m, input logic [3:0] sel,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [63:0] mask;
    longint sx, sy, ux, uy, p;
    int sh;
    mask = (64'd1 << n) - 64'd1;
    ux = longint'(x & mask);
    uy = longint'(y & mask);
    sx = x[n-1] ? longint'(x | ~mask) : ux;
    sy = y[n-1] ? longint'(y | ~mask) : uy;
    sh = int'(y & 64'(n - 1));
    if (!m) begin
      case (sel)
        4'b0000: return 64'(ux + uy) & mask;
        4'b1000: return 64'(ux - uy) & mask;
        4'b0001: return 64'(ux << sh) & mask;
        4'b0101: return 64'(ux >> sh) & mask;
        4'b1101: return 64'(sx >>> sh) & mask;
        4'b0010: return (sx < sy) ? 64'd1 : 64'd0;
        4'b0011: return (ux < uy) ? 64'd1 : 64'd0;
        4'b0100: return (x ^ y) & mask;
        4'b0110: return (x | y) & mask;
        4'b0111: return (x & y) & mask;
        4'b1111: return y & mask;
        default: return 64'd0;
      endcase
    end
    case (sel[2:0])
      3'd0: begin p = ux * uy; return 64'(p) & mask; end
      3'd1: begin p = sx * sy; return 64'(p >> n) & mask; end
      3'd2: begin p = sx * uy; return 64'(p >> n) & mask; end
      3'd3: begin p = ux * uy; return 64'(p >> n) & mask; end
      3'd4: return (sy == 0) ? mask : 64'(sx / sy) & mask;
      3'd5: return (uy == 0) ? mask : 64'(ux / uy) & mask;
      3'd6: return (sy == 0) ? 64'(ux) : 64'(sx % sy) & mask;
      default: return (uy == 0) ? 64'(ux) : 64'(ux % uy) & mask;
    endcase
  endfunction

  function automatic logic cur_ov(input int n);
    return (n == 32) ? ov32 : ov8;
  endfunction

  function automatic logic cur_ir(input int n);
    return (n == 32) ? ir32 : ir8;
  endfunction

  function automatic logic [63:0] cur_res(input int n);
    return (n == 32) ? {32'd0, r32} : {56'd0, r8};
  endfunction

  task automatic drive(input int n, input bit v, input bit m, input logic [3:0] sel,
                       input logic [63:0] x, input logic [63:0] y);
    if (n == 32) begin
      iv32 = v; m32 = m; s32 = sel; x32 = x[31:0]; y32 = y[31:0];
    end else begin
      iv8 = v; m8 = m; s8 = sel; x8 = x[7:0]; y8 = y[7:0];
    end
  endtask

  task automatic set_ready(input int n, input bit r);
    if (n == 32) or32 = r;
    else or8 = r;
  endtask

  function automatic logic [63:0] pick(input int n);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return mask;
      3: return 64'd1 << (n - 1);
      4: return mask >> 1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // One complete transaction: accept, wait for result, check latency and value, drain
  task automatic do_op(input string tag, input int n, input bit m, input logic [3:0] sel,
                       input logic [63:0] x, input logic [63:0] y, output logic [63:0] got);
    int lat;
    int exp_lat;
    logic [63:0] exp;
    exp_lat = m ? n + 2 : 1;
    exp = model(n, m, sel, x, y);
    check({tag, " in_ready"}, {63'd0, cur_ir(n)}, 64'd1);
    drive(n, 1'b1, m, sel, x, y);
    @(posedge clk); #1;
    drive(n, 1'b0, m, sel, x, y);
    lat = 1;
    while (!cur_ov(n) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    got = cur_res(n);
    check({tag, " result"}, got, exp);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    set_ready(n, 1'b1);
    @(posedge clk); #1;
    set_ready(n, 1'b0);
    check({tag, " drained"}, {63'd0, cur_ov(n)}, 64'd0);
  endtask

  initial begin
    logic [63:0] got;
    int lat;
    reset = 1'b1;
    iv32 = 1'b0; m32 = 1'b0; s32 = 4'd0; x32 = 32'd0; y32 = 32'd0; or32 = 1'b0;
    iv8 = 1'b0; m8 = 1'b0; s8 = 4'd0; x8 = 8'd0; y8 = 8'd0; or8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst in_ready32", {63'd0, ir32}, 64'd1);
    check("rst out_valid32", {63'd0, ov32}, 64'd0);
    check("rst result32", {32'd0, r32}, 64'd0);
    check("rst in_ready8", {63'd0, ir8}, 64'd1);
    check("rst out_valid8", {63'd0, ov8}, 64'd0);
    check("rst result8", {56'd0, r8}, 64'd0);

    // Base sweep
    do_op("add", 32, 1'b0, 4'b0000, 64'h7FFFFFFF, 64'h1, got);
    check("add const", got, 64'h80000000);
    do_op("sra", 32, 1'b0, 4'b1101, 64'h80000000, 64'd4, got);
    check("sra const", got, 64'hF8000000);
    do_op("slt", 32, 1'b0, 4'b0010, 64'hFFFFFFFF, 64'd1, got);
    check("slt const", got, 64'd1);
    do_op("sltu", 32, 1'b0, 4'b0011, 64'hFFFFFFFF, 64'd1, got);
    check("sltu const", got, 64'd0);
    do_op("code1001", 32, 1'b0, 4'b1001, 64'h1234, 64'h5678, got);
    check("code1001 const", got, 64'd0);

    // Multiply
    do_op("mul", 32, 1'b1, 4'b0000, 64'hFFFFFFFF, 64'd2, got);
    check("mul const", got, 64'hFFFFFFFE);
    do_op("mulh", 32, 1'b1, 4'b0001, 64'hFFFFFFFF, 64'hFFFFFFFF, got);
    check("mulh const", got, 64'd0);
    do_op("mulhu", 32, 1'b1, 4'b0011, 64'hFFFFFFFF, 64'hFFFFFFFF, got);
    check("mulhu const", got, 64'hFFFFFFFE);
    do_op("mulhsu", 32, 1'b1, 4'b1010, 64'hFFFFFFFF, 64'hFFFFFFFF, got);
    check("mulhsu const", got, 64'hFFFFFFFF);

    // Divide
    do_op("div", 32, 1'b1, 4'b0100, 64'hFFFFFFF9, 64'd2, got);
    check("div const", got, 64'hFFFFFFFD);
    do_op("rem", 32, 1'b1, 4'b0110, 64'hFFFFFFF9, 64'd2, got);
    check("rem const", got, 64'hFFFFFFFF);
    do_op("divu0", 32, 1'b1, 4'b0101, 64'd7, 64'd0, got);
    check("divu0 const", got, 64'hFFFFFFFF);
    do_op("rem0", 32, 1'b1, 4'b0110, 64'd7, 64'd0, got);
    check("rem0 const", got, 64'd7);
    do_op("divovf", 32, 1'b1, 4'b0100, 64'h80000000, 64'hFFFFFFFF, got);
    check("divovf const", got, 64'h80000000);
    do_op("removf", 32, 1'b1, 4'b0110, 64'h80000000, 64'hFFFFFFFF, got);
    check("removf const", got, 64'd0);

    // N=8 instance
    do_op("mulhu8", 8, 1'b1, 4'b0011, 64'hFF, 64'hFF, got);
    check("mulhu8 const", got, 64'hFE);
    do_op("div8", 8, 1'b1, 4'b0100, 64'h80, 64'hFF, got);
    check("div8 const", got, 64'h80);

    // Backpressure: result held, new op ignored until the cycle after out_ready
    drive(32, 1'b1, 1'b1, 4'b0000, 64'd3, 64'd5);
    @(posedge clk); #1;
    drive(32, 1'b0, 1'b1, 4'b0000, 64'd3, 64'd5);
    lat = 1;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 64'(lat), 64'd34);
    drive(32, 1'b1, 1'b0, 4'b0000, 64'd1, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp result held", {32'd0, r32}, 64'd15);
      check("bp in_ready low", {63'd0, ir32}, 64'd0);
      check("bp out_valid held", {63'd0, ov32}, 64'd1);
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    check("bp drained", {63'd0, ov32}, 64'd0);
    check("bp in_ready back", {63'd0, ir32}, 64'd1);
    @(posedge clk); #1;
    drive(32, 1'b0, 1'b0, 4'b0000, 64'd1, 64'd1);
    check("bp next valid", {63'd0, ov32}, 64'd1);
    check("bp next result", {32'd0, r32}, 64'd2);
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;

    // Reset during CALC cycle 5 of a DIV
    drive(32, 1'b1, 1'b1, 4'b0100, 64'd100, 64'd7);
    @(posedge clk); #1;
    drive(32, 1'b0, 1'b1, 4'b0100, 64'd100, 64'd7);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid out_valid", {63'd0, ov32}, 64'd0);
    check("rstmid result", {32'd0, r32}, 64'd0);
    check("rstmid in_ready", {63'd0, ir32}, 64'd1);
    repeat (40) begin
      @(posedge clk); #1;
    end
    check("rstmid no result", {63'd0, ov32}, 64'd0);
    do_op("post_rst_add", 32, 1'b0, 4'b0000, 64'd2, 64'd3, got);
    check("post_rst_add const", got, 64'd5);

    // Randomised ops on both widths
    for (int i = 0; i < 80; i++) begin
      int n;
      bit m;
      logic [3:0] sel;
      n = ((i % 3) == 0) ? 8 : 32;
      m = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      do_op("rand", n, m, sel, pick(n), pick(n), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
